// File: rtl/uart_duplex_param.sv
`default_nettype none
// ============================================================================
// Module : uart_duplex_param
// Brief  : Full-duplex UART with configurable data width, parity and stop
//          bits. TX and RX use valid/ready handshakes. RX has a receive FIFO,
//          sticky error flags and start-bit glitch rejection. Bit timing
//          advances only on the external oversample tick (enable_uart).
// Rev    : 1.0 - initial release
// ============================================================================
module uart_duplex_param #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_uart,
  input  logic                 enable_uart,
  input  logic                 enable_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_indicator,
  input  logic                 enable_rx,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overflow,
  input  logic                 err_clear,
  output logic                 rx_indicator
);

  localparam int              c_cw        = $clog2(OVERSAMPLE);
  localparam int              c_aw        = $clog2(RX_FIFO_DEPTH);
  localparam logic [c_cw-1:0] c_tick_last = c_cw'(OVERSAMPLE - 1);
  localparam logic [c_cw-1:0] c_tick_mid  = c_cw'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cw-1:0] c_tick_one  = c_cw'(1);
  localparam logic [3:0]      c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_stop_last = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- TX side
  state_t                 tx_state_q, tx_state_d;
  logic [c_cw-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;

  // Ready is held low while reset is asserted so no word is accepted then.
  assign tx_ready     = (tx_state_q == ST_IDLE) && enable_tx && !reset_uart;
  assign tx_indicator = (tx_state_q != ST_IDLE) || txd;

  // TX next state: accept a word in IDLE, otherwise step bits on each tick.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q == ST_IDLE) begin
      if (tx_valid && tx_ready) begin
        tx_state_d = ST_START;
        tx_shift_d = tx_data;
        tx_par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end
    end else if (enable_uart) begin
      tx_cnt_d = tx_cnt_q + c_tick_one;
      if (tx_cnt_q == c_tick_last) begin
        tx_cnt_d = '0;
        case (tx_state_q)
          ST_START: tx_state_d = ST_DATA;
          ST_DATA: begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 4'd1;
            if (tx_bit_q == c_data_last) begin
              tx_bit_d   = '0;
              tx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: tx_state_d = ST_STOP;
          ST_STOP: begin
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == c_stop_last) tx_state_d = ST_IDLE;
          end
          default: tx_state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Serial line level for the current TX state (idle/stop are high).
  always_comb begin
    txd = 1'b1;
    case (tx_state_q)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = tx_shift_q[0];
      ST_PARITY: txd = tx_par_q;
      default:   txd = 1'b1;
    endcase
  end

  // TX registers.
  always_ff @(posedge clock) begin
    if (reset_uart) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  // ---------------------------------------------------------------- RX side
  logic                   rxd_meta_q, rxd_sync_q, rxd_prev_q;
  state_t                 rx_state_q, rx_state_d;
  logic [c_cw-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   w_fall, w_push_req, w_frame_set, w_rx_par_exp;

  assign w_fall       = rxd_prev_q && !rxd_sync_q;
  assign w_rx_par_exp = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;
  assign rx_indicator = (rx_state_q != ST_IDLE) || rxd_sync_q;

  // RX next state: mid-bit sampling; stop sample decides push or frame error.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_perr_d   = rx_perr_q;
    w_push_req  = 1'b0;
    w_frame_set = 1'b0;
    if (!enable_rx) begin
      rx_state_d = ST_IDLE;
    end else if (rx_state_q == ST_IDLE) begin
      if (w_fall) begin
        rx_state_d = ST_START;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_perr_d  = 1'b0;
      end
    end else if (enable_uart) begin
      rx_cnt_d = rx_cnt_q + c_tick_one;
      case (rx_state_q)
        ST_START: if (rx_cnt_q == c_tick_mid) begin
          rx_cnt_d   = '0;
          rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (rx_cnt_q == c_tick_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
          if (rx_bit_q == c_data_last) begin
            rx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: if (rx_cnt_q == c_tick_last) begin
          rx_cnt_d   = '0;
          rx_perr_d  = (rxd_sync_q != w_rx_par_exp);
          rx_state_d = ST_STOP;
        end
        ST_STOP: if (rx_cnt_q == c_tick_last) begin
          rx_cnt_d    = '0;
          rx_state_d  = ST_IDLE;
          w_push_req  = rxd_sync_q;
          w_frame_set = !rxd_sync_q;
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  // RX registers, including the two-flop synchronizer and edge history.
  always_ff @(posedge clock) begin
    if (reset_uart) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // -------------------------------------------------------- FIFO and flags
  logic [c_aw:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]   mem_q [RX_FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [RX_FIFO_DEPTH];
  logic                   par_err_q, par_err_d, frame_err_q, frame_err_d;
  logic                   ovf_q, ovf_d;
  logic                   w_full, w_pop, w_push;

  assign w_full   = (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]) &&
                    (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]);
  assign rx_valid = (wr_ptr_q != rd_ptr_q);
  assign w_pop    = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push   = w_push_req && (!w_full || w_pop);
  assign rx_data  = mem_q[rd_ptr_q[c_aw-1:0]];

  assign rx_parity_err = par_err_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_overflow   = ovf_q;

  // FIFO pointer/storage update and sticky flags (clear beats set).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      mem_d[wr_ptr_q[c_aw-1:0]] = rx_shift_q;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    par_err_d   = err_clear ? 1'b0 : (par_err_q || (w_push_req && rx_perr_q));
    frame_err_d = err_clear ? 1'b0 : (frame_err_q || w_frame_set);
    ovf_d       = err_clear ? 1'b0 : (ovf_q || (w_push_req && w_full && !w_pop));
  end

  // FIFO and flag registers; reset flushes storage so rx_data reads zero.
  always_ff @(posedge clock) begin
    if (reset_uart) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_duplex_param.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_duplex_param
// Brief  : Scoreboard bench for uart_duplex_param (even-parity and odd-parity
//          instances). Stimulus pushes expected words/line levels into
//          queues; monitors pop and compare when the DUT presents output.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_duplex_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_uart, enable_uart, enable_tx, tx_valid, enable_rx, rx_ready, err_clear;
  logic [7:0] tx_data;
  logic       tx_ready, txd, tx_indicator;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_overflow, rx_indicator;
  logic       rxd_drv, lb_en, rxd;

  logic       enable_rx2, rx_ready2;
  logic       tx_ready2, txd2, tx_ind2;
  logic [7:0] rx_data2;
  logic       rx_valid2, perr2, ferr2, ovf2, rx_ind2;

  assign rxd = lb_en ? txd : rxd_drv;

  uart_duplex_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                      .OVERSAMPLE(16), .RX_FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_uart(reset_uart), .enable_uart(enable_uart),
    .enable_tx(enable_tx), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .tx_indicator(tx_indicator),
    .enable_rx(enable_rx), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_overflow(rx_overflow), .err_clear(err_clear), .rx_indicator(rx_indicator)
  );

  uart_duplex_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                      .OVERSAMPLE(16), .RX_FIFO_DEPTH(4)) dut_odd (
    .clock(clock), .reset_uart(reset_uart), .enable_uart(enable_uart),
    .enable_tx(1'b0), .tx_data(tx_data), .tx_valid(1'b0),
    .tx_ready(tx_ready2), .txd(txd2), .tx_indicator(tx_ind2),
    .enable_rx(enable_rx2), .rxd(rxd_drv), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .rx_parity_err(perr2), .rx_frame_err(ferr2),
    .rx_overflow(ovf2), .err_clear(err_clear), .rx_indicator(rx_ind2)
  );

  typedef struct packed {
    logic txd;
    logic rdy;
  } txe_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rx_exp_q [$];
  logic [7:0] rx2_exp_q [$];
  txe_t       tx_exp_q [$];
  txe_t       txe_mon;
  logic       tx_mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_tx_ready();
    int n = 0;
    while (!tx_ready && n < 400) begin
      wait_clk(1);
      n++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
  endtask

  task automatic tx_send(input logic [7:0] d);
    wait_tx_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  // Bit-bang one frame on rxd_drv: start, 8 data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxd_drv = bits[i];
      wait_clk(16);
    end
  endtask

  // Monitors: compare popped RX words and per-clock TX line levels.
  always @(negedge clock) begin
    if (rx_valid && rx_ready) begin
      if (rx_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else begin
        chk("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
      end
    end
    if (rx_valid2 && rx_ready2) begin
      if (rx2_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx2_unexpected: got %0h expected none", rx_data2);
      end else begin
        chk("rx2_data", 32'(rx_data2), 32'(rx2_exp_q.pop_front()));
      end
    end
    if (tx_mon_on && tx_exp_q.size() > 0) begin
      txe_mon = tx_exp_q.pop_front();
      chk("txd_level", 32'(txd), 32'(txe_mon.txd));
      chk("tx_ready_frame", 32'(tx_ready), 32'(txe_mon.rdy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic a5_bits [11];
    int   n;
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset_uart = 1'b1; enable_uart = 1'b1; enable_tx = 1'b1; tx_valid = 1'b0;
    tx_data = 8'h00; enable_rx = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
    rxd_drv = 1'b1; lb_en = 1'b0; enable_rx2 = 1'b0; rx_ready2 = 1'b0;

    // Reset state
    wait_clk(3);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_overflow}), 32'd0);
    reset_uart = 1'b0;
    #1;
    chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);

    // TX waveform for 0xA5, even parity
    for (int b = 0; b < 11; b++)
      for (int k = 0; k < 16; k++) tx_exp_q.push_back('{txd: a5_bits[b], rdy: 1'b0});
    tx_exp_q.push_back('{txd: 1'b1, rdy: 1'b1});
    wait_tx_ready();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid  = 1'b0;
    tx_mon_on = 1'b1;
    n = 0;
    while (tx_exp_q.size() != 0 && n < 300) begin
      wait_clk(1);
      n++;
    end
    tx_mon_on = 1'b0;
    chk("tx_frame_drained", 32'(tx_exp_q.size()), 32'd0);

    // Loopback 0x3C then 0xFF
    lb_en = 1'b1;
    rx_exp_q.push_back(8'h3C);
    rx_exp_q.push_back(8'hFF);
    tx_send(8'h3C);
    wait_tx_ready();
    wait_clk(5);
    chk("lb_rx_valid_1", 32'(rx_valid), 32'd1);
    tx_send(8'hFF);
    wait_tx_ready();
    wait_clk(5);
    rx_ready = 1'b1;
    wait_clk(3);
    rx_ready = 1'b0;
    chk("lb_rx_valid_empty", 32'(rx_valid), 32'd0);
    chk("lb_flags", 32'({rx_parity_err, rx_frame_err, rx_overflow}), 32'd0);
    chk("lb_drained", 32'(rx_exp_q.size()), 32'd0);
    lb_en = 1'b0;

    // Framing error: 0x55, parity correct (0), stop bit 0
    send_frame(8'h55, 1'b0, 1'b0);
    rxd_drv = 1'b1;
    wait_clk(20);
    chk("frame_err_set", 32'(rx_frame_err), 32'd1);
    chk("frame_err_no_push", 32'(rx_valid), 32'd0);
    err_clear = 1'b1;
    wait_clk(1);
    err_clear = 1'b0;
    chk("frame_err_cleared", 32'(rx_frame_err), 32'd0);

    // Start-bit glitch, then a good frame proves the receiver is back in IDLE
    rxd_drv = 1'b0;
    wait_clk(4);
    rxd_drv = 1'b1;
    wait_clk(30);
    chk("glitch_no_push", 32'(rx_valid), 32'd0);
    rx_exp_q.push_back(8'h5A);
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1);
    rxd_drv = 1'b1;
    wait_clk(20);
    rx_ready = 1'b0;
    chk("glitch_then_frame_drained", 32'(rx_exp_q.size()), 32'd0);
    chk("glitch_flags", 32'({rx_parity_err, rx_frame_err}), 32'd0);

    // rx_indicator follows the line while idle
    enable_rx = 1'b0;
    rxd_drv = 1'b0;
    wait_clk(4);
    chk("rx_ind_low", 32'(rx_indicator), 32'd0);
    rxd_drv = 1'b1;
    wait_clk(4);
    chk("rx_ind_high", 32'(rx_indicator), 32'd1);

    // Odd parity instance: 0x01 with wrong parity bit 1
    enable_rx2 = 1'b1;
    rx2_exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    rxd_drv = 1'b1;
    wait_clk(20);
    chk("odd_parity_err", 32'(perr2), 32'd1);
    chk("odd_pushed", 32'(rx_valid2), 32'd1);
    chk("odd_frame_ok", 32'(ferr2), 32'd0);
    rx_ready2 = 1'b1;
    wait_clk(2);
    rx_ready2 = 1'b0;
    chk("odd_drained", 32'(rx2_exp_q.size()), 32'd0);
    chk("even_inst_untouched", 32'(rx_parity_err), 32'd0);
    enable_rx2 = 1'b0;
    enable_rx  = 1'b1;

    // Overflow: five frames into a depth-4 FIFO
    lb_en = 1'b1;
    for (int i = 0; i < 4; i++) rx_exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) tx_send(8'h10 + 8'(i));
    wait_tx_ready();
    wait_clk(5);
    chk("overflow_set", 32'(rx_overflow), 32'd1);
    rx_ready = 1'b1;
    wait_clk(6);
    rx_ready = 1'b0;
    chk("overflow_fifo_empty", 32'(rx_valid), 32'd0);
    chk("overflow_drained", 32'(rx_exp_q.size()), 32'd0);
    lb_en = 1'b0;

    // Reset mid-frame
    tx_send(8'h00);
    wait_clk(40);
    chk("mid_frame_txd", 32'(txd), 32'd0);
    reset_uart = 1'b1;
    wait_clk(1);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_tx_ready", 32'(tx_ready), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_overflow", 32'(rx_overflow), 32'd0);
    reset_uart = 1'b0;
    #1;
    chk("after_reset_tx_ready", 32'(tx_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_duplex_param.md
Name: uart_duplex_param

Overview:
- Parametrised full-duplex UART. Successor to the fixed 8N1 UART pair.
- Adds configurable data width, parity and stop bits, plus valid/ready handshakes.
- RX side adds a receive FIFO, parity/framing/overflow error flags and start-bit glitch rejection.
- Sits between the CPU-side byte interface and the pins; bit timing is driven by an external oversample tick from the prescaler.

Parameters:
- DATA_BITS, 8, payload bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits (1 or 2).
- OVERSAMPLE, 16, enable_uart ticks per bit; even, at least 4.
- RX_FIFO_DEPTH, 4, RX FIFO entries; power of 2, at least 2.

Ports:
- clock  in  1  system clock.
- reset_uart  in  1  synchronous, active-high reset.
- enable_uart  in  1  one-clock oversample tick (baud * OVERSAMPLE); all bit timing advances only on this tick.
- enable_tx  in  1  transmitter enable.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a word.
- txd  out  1  serial output.
- tx_indicator  out  1  tx_busy | txd.
- enable_rx  in  1  receiver enable.
- rxd  in  1  serial input (asynchronous).
- rx_data  out  DATA_BITS  FIFO head word.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop the FIFO head.
- rx_parity_err  out  1  sticky; parity mismatch seen.
- rx_frame_err  out  1  sticky; stop bit sampled low.
- rx_overflow  out  1  sticky; a word was dropped because the FIFO was full.
- err_clear  in  1  clears the three sticky flags.
- rx_indicator  out  1  rx_busy | rxd_sync.

Behaviour:
- Reset values: txd=1, tx_ready=0 for the reset cycle then 1 if enable_tx, FIFO empty, rx_valid=0, rx_data=0, all error flags 0, both FSMs in IDLE.
- TX handshake: tx_ready = (state==IDLE) & enable_tx. Transfer happens when tx_valid & tx_ready on a clock edge; tx_data is latched into the shift register and the FSM moves to START. The START state begins on the next enable_uart tick.
- TX FSM: IDLE -> START -> DATA (DATA_BITS bits, LSB first) -> PARITY (skipped if PARITY=0) -> STOP (STOP_BITS bits, txd=1) -> IDLE.
  - Each bit is held for exactly OVERSAMPLE ticks.
  - Parity bit: odd = ~^data, even = ^data.
  - tx_busy = state != IDLE.
- Deasserting enable_tx mid-frame does not abort the frame; it only blocks new transfers.
- RX input: rxd passes through a 2-flop synchronizer to give rxd_sync.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: a falling edge on rxd_sync with enable_rx high enters START.
  - START: at tick OVERSAMPLE/2 rxd_sync is resampled. If it is 1, the event is a glitch; return to IDLE with nothing stored.
  - Later bits are sampled every OVERSAMPLE ticks from that mid-point.
  - Only the first stop bit is checked. With STOP_BITS=2 the receiver returns to IDLE after the first stop sample.
- RX completion (stop sample):
  - Stop sample 0: rx_frame_err=1 and the word is discarded.
  - Stop sample 1: the word is pushed, and it is pushed even if parity failed; rx_parity_err is set on mismatch.
  - Push while FIFO full (and no pop in the same cycle): word dropped, rx_overflow=1.
  - Pop and push in the same cycle while full: both occur.
- FIFO: rx_data is the head word; it is combinational from the storage array. Pop happens when rx_valid & rx_ready. Pointers are $clog2(RX_FIFO_DEPTH) bits wide plus a wrap bit. Empty when the pointers are equal; full when the indices are equal and the wrap bits differ.
- Sticky flags: err_clear has priority over a new set in the same cycle.
- enable_rx low forces the RX FSM to IDLE at the next clock. FIFO contents are kept.
- reset_uart mid-frame: txd returns to 1 at the next edge, the FSMs go to IDLE and the FIFO is flushed.
- enable_uart low: FSMs hold state and counters freeze.

Test Plan:
- Defaults with PARITY=2, enable_uart=1 every clock, tx_valid pulsed with tx_data=0xA5:
  - txd = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1, each bit held 16 clocks, 176 clocks total.
  - tx_ready is low for the whole frame.
- Loopback txd->rxd, send 0x3C then 0xFF:
  - rx_valid asserts after each frame, FIFO holds 0x3C then 0xFF, no error flags.
  - Pop twice and check rx_valid=0.
- Drive a frame with data 0x55 and the stop bit 0 -> rx_frame_err=1, FIFO stays empty. Then err_clear -> flag returns to 0.
- PARITY=1, frame with data 0x01 and parity bit 1 (wrong) -> rx_parity_err=1, 0x01 is pushed.
- Five back-to-back frames 0x10..0x14 with rx_ready=0, depth 4:
  - rx_overflow=1; pops return 0x10..0x13 in that order.
- rxd low for 4 ticks then high -> no push, RX FSM back in IDLE, rx_indicator follows rxd. Separately, assert reset_uart mid-TX-frame -> txd=1 on the next edge and tx_ready=1 afterwards.
